mpc_dot_acc: RTL and testbench

Signed dot-product accumulator that sits directly downstream of the 21s × 6u pipelined DSP48 multiplier in the implicit MPC datapath. It tracks operand validity through the multiplier's ce-gated pipeline and sums a burst of 28-bit products into a wide accumulator. On the last term it rounds, scales and saturates the sum to a 21-bit fixed-point result. The result is held in an output register under a valid/ready handshake.

---
 rtl/mpc_dot_acc_if.sv | 41 ++++
 rtl/mpc_dot_acc.sv | 186 ++++++++++++++++++
 tb/tb_mpc_dot_acc.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpc_dot_acc_if.sv
// mpc_dot_acc_if: bus bundle between the multiplier/consumer side and mpc_dot_acc.
//   master: drives ce, in_valid, in_last, p, out_ready; observes the result/status.
//   slave : the accumulator; consumes the term stream, produces the result/status.
// Signals:
//   ce        - pipeline enable shared with the multiplier
//   in_valid  - operands entering the multiplier form a term
//   in_last   - term closes the burst (qualified by in_valid)
//   p         - signed multiplier product, PW bits
//   out_valid - result held in out_data
//   out_ready - consumer accepts the result
//   out_data  - rounded/scaled signed result, OW bits
//   out_ovf   - result was clipped or wrapped
//   hold_req  - out_valid & ~out_ready (combinational)
//   busy      - partial sum active or terms in flight
//   ovr_err   - sticky: a result or term count was lost
interface mpc_dot_acc_if #(
    parameter int unsigned PW = 28,
    parameter int unsigned OW = 21
);
    logic                 ce;
    logic                 in_valid;
    logic                 in_last;
    logic signed [PW-1:0] p;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_data;
    logic                 out_ovf;
    logic                 hold_req;
    logic                 busy;
    logic                 ovr_err;

    modport master (
        output ce, in_valid, in_last, p, out_ready,
        input  out_valid, out_data, out_ovf, hold_req, busy, ovr_err
    );

    modport slave (
        input  ce, in_valid, in_last, p, out_ready,
        output out_valid, out_data, out_ovf, hold_req, busy, ovr_err
    );
endinterface

// File: rtl/mpc_dot_acc.sv
// mpc_dot_acc: signed dot-product accumulator behind a ce-gated pipelined multiplier.
// Tracks term validity through a MUL_LAT-deep delay line so that the last stage
// lines up with the product p, sums each burst into an AW-bit accumulator, then
// rounds (half toward +inf), shifts right by FRAC_SH and clips to OW bits.
// The result is held under a valid/ready handshake.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - mpc_dot_acc_if.slave (ce, term stream, result handshake, status)
// Build option:
//   MPC_DOT_ACC_SAT_EN - defined: saturate the result; undefined: two's-complement wrap.
//   out_ovf reports the out-of-range condition in both builds.
module mpc_dot_acc #(
    parameter int unsigned PW      = 28,
    parameter int unsigned AW      = 36,
    parameter int unsigned OW      = 21,
    parameter int unsigned FRAC_SH = 6,
    parameter int unsigned MUL_LAT = 3
) (
    input logic          clk,
    input logic          rst_n,
    mpc_dot_acc_if.slave bus
);

    localparam int unsigned SW = AW + 1;  // one guard bit for the rounding add
    localparam int unsigned CW = 8;
    localparam logic signed [SW-1:0] RND = SW'(1) << (FRAC_SH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // delay line
    logic [MUL_LAT-1:0]   r_v;
    logic [MUL_LAT-1:0]   r_l;

    // accumulate stage
    state_t               r_state;
    state_t               w_state_nxt;
    logic signed [AW-1:0] r_acc;
    logic signed [AW-1:0] w_acc_nxt;
    logic signed [AW-1:0] w_p_ext;
    logic [CW-1:0]        r_cnt;      // terms in current burst minus one
    logic [CW-1:0]        w_cnt_nxt;
    logic                 w_cnt_ovf;
    logic                 r_fin;
    logic                 w_fin_nxt;
    logic                 w_term;

    // finalise stage
    logic signed [SW-1:0] w_sum;
    logic signed [SW-1:0] w_r;
    logic [SW-OW:0]       w_hi;
    logic                 w_ovf;
    logic signed [OW-1:0] w_res;

    // output stage
    logic                 r_out_valid;
    logic signed [OW-1:0] r_out_data;
    logic                 r_out_ovf;
    logic                 r_ovr_err;
    logic                 w_can_load;
    logic                 w_accept;
    logic                 w_lost;

    // Validity/last delay line; advances with the multiplier pipeline only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
            r_l <= '0;
        end else if (bus.ce) begin
            r_v[0] <= bus.in_valid;
            r_l[0] <= bus.in_valid & bus.in_last;
            for (int i = 1; i < int'(MUL_LAT); i++) begin
                r_v[i] <= r_v[i-1];
                r_l[i] <= r_l[i-1];
            end
        end
    end

    assign w_p_ext = AW'(bus.p);
    assign w_term  = bus.ce & r_v[MUL_LAT-1];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and accumulate-stage updates
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_cnt_ovf   = 1'b0;
        w_fin_nxt   = 1'b0;
        if (w_term) begin
            w_fin_nxt = r_l[MUL_LAT-1];
            case (r_state)
                IDLE: begin
                    w_acc_nxt   = w_p_ext;
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_l[MUL_LAT-1] ? IDLE : ACC;
                end
                ACC: begin
                    w_acc_nxt = r_acc + w_p_ext;
                    // count pinned at 256 terms; every further term is an overrun
                    if (r_cnt == '1) begin
                        w_cnt_ovf = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                    if (r_l[MUL_LAT-1]) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Accumulator, term counter and finalise strobe. acc keeps the closed
    // burst's sum until the next burst's first term overwrites it, which
    // is never earlier than the finalise cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_fin <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            r_fin <= w_fin_nxt;
        end
    end

    // Round half toward +inf, scale, and range-check against OW bits.
    always_comb begin
        w_sum = SW'(r_acc) + RND;
        w_r   = w_sum >>> FRAC_SH;
        w_hi  = w_r[SW-1:OW-1];
        w_ovf = ~((&w_hi) | ~(|w_hi));
        w_res = w_r[OW-1:0];
`ifdef MPC_DOT_ACC_SAT_EN
        if (w_ovf) begin
            w_res = w_r[SW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        end
`endif
    end

    assign w_accept   = r_out_valid & bus.out_ready;
    assign w_can_load = ~r_out_valid | bus.out_ready;
    assign w_lost     = r_fin & ~w_can_load;

    // Output register; runs independently of ce so a held result can drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
            r_ovr_err   <= 1'b0;
        end else begin
            if (r_fin && w_can_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_res;
                r_out_ovf   <= w_ovf;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
            r_ovr_err <= r_ovr_err | w_lost | w_cnt_ovf;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ovf   = r_out_ovf;
    assign bus.ovr_err   = r_ovr_err;
    // combinational so the top level can drop ce in the same cycle
    assign bus.hold_req  = r_out_valid & ~bus.out_ready;
    assign bus.busy      = (r_state == ACC) | (|r_v);

endmodule

// File: tb/tb_mpc_dot_acc.sv
module tb_mpc_dot_acc;

    localparam int unsigned PW      = 28;
    localparam int unsigned AW      = 36;
    localparam int unsigned OW      = 21;
    localparam int unsigned FRAC_SH = 6;
    localparam int unsigned MUL_LAT = 3;

    logic clk;
    logic rst_n;
    mpc_dot_acc_if #(.PW(PW), .OW(OW)) bus ();

    mpc_dot_acc #(
        .PW(PW), .AW(AW), .OW(OW), .FRAC_SH(FRAC_SH), .MUL_LAT(MUL_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: 21s x 6u, MUL_LAT ce-gated stages, no reset.
    logic signed [20:0]   a;
    logic [5:0]           b;
    logic signed [PW-1:0] mpipe [MUL_LAT];
    initial for (int i = 0; i < int'(MUL_LAT); i++) mpipe[i] = '0;
    always @(posedge clk) begin
        if (bus.ce) begin
            mpipe[0] <= PW'(a * $signed({1'b0, b}));
            for (int i = 1; i < int'(MUL_LAT); i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign bus.p = mpipe[MUL_LAT-1];

    int n_cmp = 0;
    int n_err = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Accepted-result monitor
    bit     mon_en = 1'b0;
    longint got_d[$];
    longint got_o[$];
    longint got_t[$];
    always @(negedge clk) begin
        if (mon_en && bus.out_valid && bus.out_ready) begin
            got_d.push_back(longint'(bus.out_data));
            got_o.push_back(longint'(bus.out_ovf));
            got_t.push_back(cyc);
        end
    end

    int ta  [260];
    int tbb [260];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: exact integer sum, floor((sum + half) / 2^FRAC_SH), then range handling.
    function automatic void ref_res(input longint sum, output longint d, output longint o);
        longint r;
        longint maxv;
        longint minv;
        maxv = (longint'(1) << (OW - 1)) - 1;
        minv = -(longint'(1) << (OW - 1));
        r = (sum + (longint'(1) << (FRAC_SH - 1))) >>> FRAC_SH;
        o = (r > maxv || r < minv) ? 1 : 0;
`ifdef MPC_DOT_ACC_SAT_EN
        d = (r > maxv) ? maxv : ((r < minv) ? minv : r);
`else
        d = (r <<< (64 - OW)) >>> (64 - OW);
`endif
    endfunction

    function automatic longint model_sum(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) s += longint'(ta[i]) * longint'(tbb[i]);
        return s;
    endfunction

    // Drive n terms from ta/tbb; optional ce=0 gap of gap_len cycles before term gap_at.
    task automatic run_burst(input int n, input int gap_at, input int gap_len);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_last  = (i == n - 1);
            a = 21'(ta[i]);
            b = 6'(tbb[i]);
            if (i == gap_at) begin
                bus.ce = 1'b0;
                repeat (gap_len) tick;
                bus.ce = 1'b1;
            end
            tick;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick;
            n++;
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic single(input int av, input int bv, output int lat);
        ta[0] = av; tbb[0] = bv;
        run_burst(1, -1, 0);
        wait_out(lat);
    endtask

    initial begin
        int lat;
        longint ed, eo;
        rst_n = 1'b0;
        bus.ce = 1'b1; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        a = '0; b = '0;
        repeat (3) tick;

        // reset values
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_out_data",  longint'(bus.out_data), 0);
        chk("rst_out_ovf",   longint'(bus.out_ovf), 0);
        chk("rst_hold_req",  longint'(bus.hold_req), 0);
        chk("rst_busy",      longint'(bus.busy), 0);
        chk("rst_ovr_err",   longint'(bus.ovr_err), 0);
        rst_n = 1'b1;
        tick;

        // single term 64*1, held under out_ready=0
        single(64, 1, lat);
        chk("single_latency", longint'(lat), 4);
        chk("single_data", longint'(bus.out_data), 1);
        chk("single_ovf",  longint'(bus.out_ovf), 0);
        chk("single_hold_req", longint'(bus.hold_req), 1);
        bus.out_ready = 1'b1;
        tick;
        chk("single_accepted", longint'(bus.out_valid), 0);

        // rounding
        single(-96, 1, lat);
        chk("rnd_m96_valid", longint'(bus.out_valid), 1);
        chk("rnd_m96", longint'(bus.out_data), -1);
        single(31, 1, lat);
        chk("rnd_31_valid", longint'(bus.out_valid), 1);
        chk("rnd_31", longint'(bus.out_data), 0);
        single(32, 1, lat);
        chk("rnd_32_valid", longint'(bus.out_valid), 1);
        chk("rnd_32", longint'(bus.out_data), 1);

        // out-of-range: 4 x (-1048576 * 63)
        for (int i = 0; i < 4; i++) begin ta[i] = -1048576; tbb[i] = 63; end
        run_burst(4, -1, 0);
        wait_out(lat);
        chk("sat_valid", longint'(bus.out_valid), 1);
`ifdef MPC_DOT_ACC_SAT_EN
        chk("sat_data", longint'(bus.out_data), -1048576);
`else
        chk("sat_data", longint'(bus.out_data), 65536);
`endif
        chk("sat_ovf", longint'(bus.out_ovf), 1);
        tick;

        // back-to-back bursts {64,64} then {128}
        got_d.delete(); got_o.delete(); got_t.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_last  = (i >= 1);
            a = (i == 2) ? 21'sd128 : 21'sd64;
            b = 6'd1;
            tick;
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        repeat (8) tick;
        mon_en = 1'b0;
        chk("b2b_count", longint'(got_d.size()), 2);
        if (got_d.size() == 2) begin
            chk("b2b_first",  got_d[0], 2);
            chk("b2b_second", got_d[1], 2);
            chk("b2b_consecutive", got_t[1] - got_t[0], 1);
        end
        chk("b2b_busy_idle", longint'(bus.busy), 0);
        chk("b2b_no_ovr",    longint'(bus.ovr_err), 0);

        // ce gap: same burst with and without a 5-cycle ce=0 hole
        ta[0] = 1000;    tbb[0] = 5;
        ta[1] = -2000;   tbb[1] = 7;
        ta[2] = 300000;  tbb[2] = 63;
        ta[3] = -5;      tbb[3] = 1;
        ref_res(model_sum(4), ed, eo);
        run_burst(4, -1, 0);
        wait_out(lat);
        chk("nogap_valid", longint'(bus.out_valid), 1);
        chk("nogap_data", longint'(bus.out_data), ed);
        tick;
        run_burst(4, 2, 5);
        wait_out(lat);
        chk("gap_valid", longint'(bus.out_valid), 1);
        chk("gap_data", longint'(bus.out_data), ed);
        chk("gap_ovf",  longint'(bus.out_ovf), eo);
        tick;

        // backpressure: second result lost while the first is held
        bus.out_ready = 1'b0;
        single(64, 1, lat);
        single(128, 1, lat);
        repeat (6) tick;
        chk("bp_valid", longint'(bus.out_valid), 1);
        chk("bp_data_held", longint'(bus.out_data), 1);
        chk("bp_hold_req", longint'(bus.hold_req), 1);
        chk("bp_ovr_err", longint'(bus.ovr_err), 1);
        bus.out_ready = 1'b1;
        tick;
        chk("bp_drained", longint'(bus.out_valid), 0);
        chk("bp_hold_clear", longint'(bus.hold_req), 0);

        // reset mid-burst with terms in flight
        bus.in_valid = 1'b1; bus.in_last = 1'b0; a = 21'sd1000; b = 6'd10;
        tick; tick;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", longint'(bus.out_valid), 0);
        chk("mrst_out_data",  longint'(bus.out_data), 0);
        chk("mrst_out_ovf",   longint'(bus.out_ovf), 0);
        chk("mrst_hold_req",  longint'(bus.hold_req), 0);
        chk("mrst_busy",      longint'(bus.busy), 0);
        chk("mrst_ovr_err",   longint'(bus.ovr_err), 0);
        tick;
        rst_n = 1'b1;
        ta[0] = 64; tbb[0] = 1; ta[1] = 64; tbb[1] = 1;
        run_burst(2, -1, 0);
        wait_out(lat);
        chk("mrst_next_valid", longint'(bus.out_valid), 1);
        chk("mrst_next_data", longint'(bus.out_data), 2);
        tick;

        // term counter: 256 terms fine, 257th flags overrun
        do_reset;
        for (int i = 0; i < 257; i++) begin ta[i] = 1; tbb[i] = 1; end
        run_burst(256, -1, 0);
        wait_out(lat);
        chk("cnt256_data", longint'(bus.out_data), 4);
        chk("cnt256_ovr",  longint'(bus.ovr_err), 0);
        tick;
        run_burst(257, -1, 0);
        wait_out(lat);
        chk("cnt257_data", longint'(bus.out_data), 4);
        chk("cnt257_ovr",  longint'(bus.ovr_err), 1);
        tick;

        // randomized bursts with random ce, checked against the reference
        begin
            longint exp_d[$];
            longint exp_o[$];
            do_reset;
            got_d.delete(); got_o.delete(); got_t.delete();
            mon_en = 1'b1;
            for (int k = 0; k < 40; k++) begin
                int len;
                len = int'($urandom_range(1, 6));
                for (int i = 0; i < len; i++) begin
                    ta[i]  = int'($urandom_range(0, 2097151)) - 1048576;
                    tbb[i] = int'($urandom_range(0, 63));
                end
                ref_res(model_sum(len), ed, eo);
                exp_d.push_back(ed);
                exp_o.push_back(eo);
                for (int i = 0; i < len; i++) begin
                    bus.in_valid = 1'b1;
                    bus.in_last  = (i == len - 1);
                    a = 21'(ta[i]);
                    b = 6'(tbb[i]);
                    do begin
                        bus.ce = ($urandom_range(0, 3) != 0);
                        tick;
                    end while (!bus.ce);
                end
                bus.in_valid = 1'b0; bus.in_last = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    bus.ce = $urandom_range(0, 1) != 0;
                    tick;
                end
            end
            bus.ce = 1'b1;
            repeat (10) tick;
            mon_en = 1'b0;
            chk("rand_count", longint'(got_d.size()), longint'(exp_d.size()));
            for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
                chk($sformatf("rand_data[%0d]", i), got_d[i], exp_d[i]);
                chk($sformatf("rand_ovf[%0d]", i),  got_o[i], exp_o[i]);
            end
            chk("rand_ovr_err", longint'(bus.ovr_err), 0);
            chk("rand_busy", longint'(bus.busy), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
